square_wave_gen: RTL and testbench

Programmable square-wave generator. It is the stimulus and output counterpart of `freq_detector_square`: it produces a digital square wave whose period and high time are given in `clk` cycles. Those are the same units `freq_detector_square` reports on `period`, so the two blocks can be looped back for self-check. Configuration goes through a valid/ready handshake and takes effect only on period boundaries, so the output never glitches.

---
 rtl/square_gen_pkg.sv | 25 ++
 rtl/square_wave_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_square_wave_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/square_gen_pkg.sv
// Shared types and default widths for the programmable square-wave generator.
//
// Contents:
//   PERIOD_W_DEF  default width of period / high-time fields (matches the detector period width)
//   CNT_W_DEF     default width of the burst cycle count
//   sq_state_t    generator state (idle, high phase, low phase)
//   cfg_t         one configuration record {period, high, cycles} at default widths
package square_gen_pkg;

   localparam int unsigned PERIOD_W_DEF = 18;
   localparam int unsigned CNT_W_DEF    = 16;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } sq_state_t;

   typedef struct packed {
      logic [PERIOD_W_DEF-1:0] period;
      logic [PERIOD_W_DEF-1:0] high;
      logic [CNT_W_DEF-1:0]    cycles;
   } cfg_t;

endpackage

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator. Produces a wave of period P and high time H (both in clk
// cycles) for N periods (N = 0: run until stopped). Configuration is double-buffered: an accepted
// configuration sits in a shadow set and is copied to the active set only in IDLE or on the
// cycle that ends a LOW phase, so the output never glitches mid-period.
//
// Ports:
//   clk          sole clock
//   rst          synchronous active-high reset
//   cfg_valid    configuration offered; accepted when cfg_valid && cfg_ready
//   cfg_ready    shadow set empty
//   cfg_period   full period P
//   cfg_high     high time H
//   cfg_cycles   burst length N in periods, 0 = continuous
//   start        leave IDLE (ignored unless an active configuration exists and stop is low)
//   stop         graceful stop: the current period completes first
//   signal_out   generated square wave
//   busy         generator not in IDLE
//   done         one-cycle pulse on return to IDLE
//   cfg_err      one-cycle pulse when an accepted configuration is invalid (dropped)
//   period_cnt   periods completed since the last start, saturating
module square_wave_gen
   import square_gen_pkg::*;
#(
   parameter int unsigned PERIOD_W = PERIOD_W_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_high,
   input  logic [CNT_W-1:0]    cfg_cycles,
   input  logic                start,
   input  logic                stop,
   output logic                signal_out,
   output logic                busy,
   output logic                done,
   output logic                cfg_err,
   output logic [CNT_W-1:0]    period_cnt
);

   sq_state_t state_q, state_d;

   logic [PERIOD_W-1:0] phase_q, phase_d;

   // Active configuration drives the waveform.
   logic [PERIOD_W-1:0] act_period_q, act_period_d;
   logic [PERIOD_W-1:0] act_high_q, act_high_d;
   logic [CNT_W-1:0]    act_cycles_q, act_cycles_d;

   // Shadow configuration waiting for the next apply point.
   logic [PERIOD_W-1:0] shd_period_q, shd_period_d;
   logic [PERIOD_W-1:0] shd_high_q, shd_high_d;
   logic [CNT_W-1:0]    shd_cycles_q, shd_cycles_d;
   logic                pend_q, pend_d;

   logic                stop_q, stop_d;
   logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;

   logic signal_out_q, signal_out_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic cfg_err_q, cfg_err_d;

   logic                cfg_fire;
   logic                cfg_ok;
   logic                phase_last;
   logic                boundary;
   logic                apply;
   logic                go;
   logic                finish;
   logic [PERIOD_W-1:0] low_len;
   logic [CNT_W-1:0]    cnt_inc;

   // ---------------------------------------------------------------------------------------
   // Shared decode
   // ---------------------------------------------------------------------------------------
   always_comb begin
      cfg_fire   = cfg_valid && !pend_q;
      cfg_ok     = (cfg_period >= PERIOD_W'(2)) && (cfg_high >= PERIOD_W'(1)) &&
                   (cfg_high < cfg_period);
      phase_last = (phase_q == '0);
      // Last LOW cycle: the edge that closes one period and may open the next.
      boundary   = (state_q == StLow) && phase_last;
      apply      = pend_q && ((state_q == StIdle) || boundary);
      // Start is judged against the post-apply active set so the first HIGH uses it.
      go         = (state_q == StIdle) && start && !stop && (act_period_d != '0);
      // Wraps to 0 when period_cnt is saturated, so a saturated count never matches N.
      cnt_inc    = period_cnt_q + CNT_W'(1);
      // The burst test uses the configuration that governed the period just ending.
      finish     = boundary &&
                   (stop_q || stop || ((act_cycles_q != '0) && (cnt_inc == act_cycles_q)));
      // Validity (1 <= H < P) keeps this at least 1.
      low_len    = act_period_q - act_high_q;
   end

   // ---------------------------------------------------------------------------------------
   // Configuration, stop latch and period counter
   // ---------------------------------------------------------------------------------------
   always_comb begin
      act_period_d = act_period_q;
      act_high_d   = act_high_q;
      act_cycles_d = act_cycles_q;
      shd_period_d = shd_period_q;
      shd_high_d   = shd_high_q;
      shd_cycles_d = shd_cycles_q;
      pend_d       = pend_q;
      stop_d       = stop_q;
      period_cnt_d = period_cnt_q;

      if (apply) begin
         act_period_d = shd_period_q;
         act_high_d   = shd_high_q;
         act_cycles_d = shd_cycles_q;
         pend_d       = 1'b0;
      end

      // Accept needs pend_q clear and apply needs it set, so the two never coincide.
      if (cfg_fire && cfg_ok) begin
         shd_period_d = cfg_period;
         shd_high_d   = cfg_high;
         shd_cycles_d = cfg_cycles;
         pend_d       = 1'b1;
      end

      if (state_d == StIdle) begin
         stop_d = 1'b0;
      end else if ((state_q != StIdle) && stop) begin
         stop_d = 1'b1;
      end

      if (go) begin
         period_cnt_d = '0;
      end else if (boundary && !(&period_cnt_q)) begin
         period_cnt_d = cnt_inc;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;

      unique case (state_q)
         StIdle: begin
            if (go) begin
               state_d = StHigh;
               phase_d = act_high_d - PERIOD_W'(1);
            end
         end
         StHigh: begin
            if (phase_last) begin
               state_d = StLow;
               phase_d = low_len - PERIOD_W'(1);
            end else begin
               phase_d = phase_q - PERIOD_W'(1);
            end
         end
         StLow: begin
            if (phase_last) begin
               if (finish) begin
                  state_d = StIdle;
               end else begin
                  state_d = StHigh;
                  phase_d = act_high_d - PERIOD_W'(1);
               end
            end else begin
               phase_d = phase_q - PERIOD_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Output logic (registered, so decoded from the next state)
   // ---------------------------------------------------------------------------------------
   always_comb begin
      signal_out_d = (state_d == StHigh);
      busy_d       = (state_d != StIdle);
      done_d       = finish;
      cfg_err_d    = cfg_fire && !cfg_ok;
   end

   // ---------------------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         phase_q      <= '0;
         act_period_q <= '0;
         act_high_q   <= '0;
         act_cycles_q <= '0;
         shd_period_q <= '0;
         shd_high_q   <= '0;
         shd_cycles_q <= '0;
         pend_q       <= 1'b0;
         stop_q       <= 1'b0;
         period_cnt_q <= '0;
         signal_out_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         act_period_q <= act_period_d;
         act_high_q   <= act_high_d;
         act_cycles_q <= act_cycles_d;
         shd_period_q <= shd_period_d;
         shd_high_q   <= shd_high_d;
         shd_cycles_q <= shd_cycles_d;
         pend_q       <= pend_d;
         stop_q       <= stop_d;
         period_cnt_q <= period_cnt_d;
         signal_out_q <= signal_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign cfg_ready  = !pend_q;
   assign signal_out = signal_out_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_square_wave_gen.sv
// Bench for square_wave_gen. The reference model plans each run as a list of whole periods
// (start time, P, H) from the configuration rules, then derives every expected output sample
// from plain arithmetic on that list.
module tb_square_wave_gen;
   import square_gen_pkg::*;

   localparam int unsigned PW = PERIOD_W_DEF;
   localparam int unsigned CW = CNT_W_DEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [PW-1:0] cfg_period;
   logic [PW-1:0] cfg_high;
   logic [CW-1:0] cfg_cycles;
   logic          start;
   logic          stop;
   logic          signal_out;
   logic          busy;
   logic          done;
   logic          cfg_err;
   logic [CW-1:0] period_cnt;

   typedef struct {
      int   t;
      cfg_t c;
   } cfg_ev_t;

   int      n_vec = 0;
   int      n_bad = 0;
   cfg_t    act;       // model of the active configuration
   cfg_ev_t ev_q[$];   // configurations offered during the next run

   square_wave_gen #(
      .PERIOD_W (PW),
      .CNT_W    (CW)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_cycles (cfg_cycles),
      .start      (start),
      .stop       (stop),
      .signal_out (signal_out),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .period_cnt (period_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit cfg_is_ok(cfg_t c);
      return (c.period >= 2) && (c.high >= 1) && (c.high < c.period);
   endfunction

   function automatic cfg_t mk(int p, int h, int n);
      cfg_t c;
      c.period = PW'(p);
      c.high   = PW'(h);
      c.cycles = CW'(n);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cfg(input cfg_t c);
      cfg_valid  = 1'b1;
      cfg_period = c.period;
      cfg_high   = c.high;
      cfg_cycles = c.cycles;
   endtask

   // Offer a configuration while idle and let it apply.
   task automatic cfg_idle(input string tag, input cfg_t c);
      chk({tag, "_ready_pre"}, cfg_ready, 1);
      drive_cfg(c);
      tick();
      cfg_valid = 1'b0;
      if (cfg_is_ok(c)) begin
         chk({tag, "_ready_pend"}, cfg_ready, 0);
         chk({tag, "_no_err"}, cfg_err, 0);
         tick();
         chk({tag, "_ready_apply"}, cfg_ready, 1);
         act = c;
      end else begin
         chk({tag, "_err"}, cfg_err, 1);
         chk({tag, "_ready_drop"}, cfg_ready, 1);
         tick();
         chk({tag, "_err_pulse"}, cfg_err, 0);
      end
   endtask

   // Start request that must be ignored.
   task automatic try_start(input string tag, input bit stop_v);
      start = 1'b1;
      stop  = stop_v;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk({tag, "_sig"}, signal_out, 0);
      chk({tag, "_busy"}, busy, 0);
      tick();
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy2"}, busy, 0);
   endtask

   // Start from IDLE and follow the run until done. Time t counts edges from the start edge;
   // stop_at / event times are the sample times after which the input is driven.
   task automatic run_wave(input string name, input int stop_at);
      int          ps[$];
      int          ph[$];
      cfg_t        cur;
      cfg_t        nxt;
      int          s, b, k, tend, e_v, b_apply, vi, j, nmis, bad_t;
      bit          pend, fin, rdy, er;
      logic [20:0] o, x, bad_o, bad_x;

      vi = -1;
      foreach (ev_q[i]) if (cfg_is_ok(ev_q[i].c)) vi = i;
      pend    = (vi >= 0);
      e_v     = pend ? ev_q[vi].t + 1 : -1;
      nxt     = pend ? ev_q[vi].c : act;
      b_apply = -1;
      cur     = act;
      s       = 0;
      k       = 0;
      b       = 0;
      fin     = 1'b0;
      while (!fin) begin
         ps.push_back(s);
         ph.push_back(int'(cur.high));
         b = s + int'(cur.period);
         k++;
         fin = (stop_at >= 0 && stop_at < b) ||
               (cur.cycles != 0 && k == int'(cur.cycles)) || (k >= 4000);
         // A config accepted strictly before this boundary takes over from here.
         if (pend && e_v < b) begin
            cur     = nxt;
            pend    = 1'b0;
            b_apply = b;
         end
         s = b;
      end
      tend = b;
      // Accepted on the final boundary: applied in IDLE one cycle later.
      if (pend && e_v <= tend) begin
         cur     = nxt;
         b_apply = tend + 1;
      end
      act = cur;

      start = 1'b1;
      tick();
      start = 1'b0;
      nmis  = 0;
      bad_t = -1;
      bad_o = '0;
      bad_x = '0;
      j     = 0;
      for (int t = 0; t <= tend; t++) begin
         while (j + 1 < ps.size() && t >= ps[j+1]) j++;
         rdy = !(b_apply >= 0 && t >= e_v && t < b_apply);
         er  = 1'b0;
         foreach (ev_q[i]) begin
            if (!cfg_is_ok(ev_q[i].c) && ev_q[i].t + 1 == t &&
                !(b_apply >= 0 && ev_q[i].t >= e_v && ev_q[i].t < b_apply)) er = 1'b1;
         end
         if (t < tend) x = {((t - ps[j]) < ph[j]), 1'b1, 1'b0, rdy, er, 16'(j)};
         else          x = {1'b0, 1'b0, 1'b1, rdy, er, 16'(k)};
         o = {signal_out, busy, done, cfg_ready, cfg_err, period_cnt};
         if (o !== x) begin
            if (nmis == 0) begin
               bad_t = t;
               bad_o = o;
               bad_x = x;
            end
            nmis++;
         end
         if (t < tend) begin
            foreach (ev_q[i]) if (ev_q[i].t == t) drive_cfg(ev_q[i].c);
            stop = (t == stop_at);
            tick();
            cfg_valid = 1'b0;
            stop      = 1'b0;
         end
      end
      n_vec++;
      assert (nmis === 0)
      else begin
         n_bad++;
         $error("FAIL %s_wave: %0d bad samples, first t=%0d observed %h expected %h",
                name, nmis, bad_t, bad_o, bad_x);
      end
      chk({name, "_done"}, done, 1);
      chk({name, "_cnt"}, period_cnt, k);
      if (b_apply == tend + 1) begin
         tick();
         chk({name, "_apply_idle"}, cfg_ready, 1);
      end
      ev_q.delete();
   endtask

   initial begin
      cfg_ev_t e;
      cfg_t    c;
      cfg_t    c2;
      int      sa;

      rst        = 1'b1;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_high   = '0;
      cfg_cycles = '0;
      start      = 1'b0;
      stop       = 1'b0;
      act        = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_sig", signal_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_cnt", period_cnt, 0);

      // No configuration yet: start is ignored.
      try_start("noconf", 1'b0);

      // Continuous, stopped during LOW of the fourth period; restart in the done cycle.
      cfg_idle("c40", mk(40, 20, 0));
      run_wave("cont", 145);
      run_wave("restart", 10);

      // Burst of 20 periods.
      cfg_idle("c120", mk(120, 60, 20));
      run_wave("burst", -1);
      tick();
      chk("burst_done_once", done, 0);
      chk("burst_idle_sig", signal_out, 0);

      // Live reconfiguration mid-HIGH.
      cfg_idle("c40b", mk(40, 20, 0));
      e.t = 5;
      e.c = mk(1040, 520, 0);
      ev_q.push_back(e);
      run_wave("live", 200);

      // Two invalid configurations while running.
      cfg_idle("c40c", mk(40, 20, 0));
      e.t = 3;
      e.c = mk(1, 1, 0);
      ev_q.push_back(e);
      e.t = 50;
      e.c = mk(40, 40, 0);
      ev_q.push_back(e);
      run_wave("inval", 150);

      // Configuration accepted exactly on a period boundary.
      cfg_idle("c40d", mk(40, 20, 0));
      e.t = 39;
      e.c = mk(30, 7, 0);
      ev_q.push_back(e);
      run_wave("bound", 90);

      // Stop together with start in IDLE.
      try_start("stopstart", 1'b1);

      // Randomised runs.
      for (int r = 0; r < 12; r++) begin
         c.period = PW'($urandom_range(50, 2));
         c.high   = PW'($urandom_range(int'(c.period) - 1, 1));
         c.cycles = CW'($urandom_range(5, 0));
         if (r % 3 == 0) begin
            c2.period = PW'($urandom_range(50, 0));
            c2.high   = c2.period;
            c2.cycles = '0;
            cfg_idle($sformatf("rbad%0d", r), c2);
         end
         cfg_idle($sformatf("rcfg%0d", r), c);
         sa = int'($urandom_range(200, 0));
         if (r % 2 == 1) begin
            c2.period = PW'($urandom_range(50, 2));
            c2.high   = PW'($urandom_range(int'(c2.period) - 1, 1));
            c2.cycles = CW'($urandom_range(5, 0));
            e.t = int'($urandom_range(2 * int'(c.period), 0));
            e.c = c2;
            ev_q.push_back(e);
         end else if (r % 4 == 2) begin
            c2.period = PW'($urandom_range(50, 0));
            c2.high   = c2.period;
            c2.cycles = '0;
            e.t = int'($urandom_range(2 * int'(c.period), 0));
            e.c = c2;
            ev_q.push_back(e);
         end
         run_wave($sformatf("rnd%0d", r), sa);
      end

      // Reset mid-HIGH with a configuration pending.
      cfg_idle("c40e", mk(40, 20, 0));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rh_sig_hi", signal_out, 1);
      tick();
      tick();
      drive_cfg(mk(50, 10, 0));
      tick();
      cfg_valid = 1'b0;
      chk("rh_pend", cfg_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rh_sig", signal_out, 0);
      chk("rh_busy", busy, 0);
      chk("rh_done", done, 0);
      chk("rh_ready", cfg_ready, 1);
      chk("rh_cnt", period_cnt, 0);
      tick();
      chk("rh_done2", done, 0);
      act = '0;
      try_start("postrst", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
